// File: rtl/prbs_checker.sv
// Self-synchronising checker for the XNOR-feedback PRBS generator.
// Fills, verifies a run of predicted bits, then flywheels and counts errors.
module prbs_checker #(
   parameter int unsigned         LFSR_LEN   = 7,
   parameter logic [LFSR_LEN-1:0] TAPS       = 7'b1100000,
   parameter int unsigned         LOCK_COUNT = 16,
   parameter int unsigned         WINDOW     = 64,
   parameter int unsigned         ERR_THRESH = 4,
   parameter int unsigned         CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   input  logic                 din,
   input  logic                 clear_cnt,
   output logic                 locked,
   output logic                 err,
   output logic [CNT_WIDTH-1:0] err_count
);

   localparam int unsigned FILL_W = $clog2(LFSR_LEN + 1);
   localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
   localparam int unsigned WERR_W = $clog2(ERR_THRESH + 1);

   typedef enum logic [1:0] {
      FILL,
      VERIFY,
      LOCKED
   } state_t;

   state_t              state;
   logic [LFSR_LEN-1:0] sr;
   logic [FILL_W-1:0]   fill_cnt;
   logic [GOOD_W-1:0]   good_cnt;
   logic [WIN_W-1:0]    win_cnt;
   logic [WERR_W-1:0]   win_err;

   logic pred;
   logic sr_lockup;
   logic mismatch;

   always_comb begin
      pred      = ~^(sr & TAPS);
      sr_lockup = &sr;
      mismatch  = din ^ pred;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         sr        <= '0;
         fill_cnt  <= '0;
         good_cnt  <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         err <= 1'b0;
         if (din_valid) begin
            case (state)
               FILL: begin
                  sr <= {sr[LFSR_LEN-2:0], din};
                  if (fill_cnt == FILL_W'(LFSR_LEN - 1)) begin
                     fill_cnt <= '0;
                     state    <= VERIFY;
                  end else begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
               end
               VERIFY: begin
                  sr <= {sr[LFSR_LEN-2:0], din};
                  if (mismatch || sr_lockup) begin
                     good_cnt <= '0;
                  end else if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                     good_cnt <= '0;
                     state    <= LOCKED;
                     locked   <= 1'b1;
                  end else begin
                     good_cnt <= good_cnt + 1'b1;
                  end
               end
               LOCKED: begin
                  // Flywheel: the prediction, not din, feeds sr so one flip is one error.
                  sr <= {sr[LFSR_LEN-2:0], pred};
                  if (mismatch) begin
                     err <= 1'b1;
                     if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                     end
                  end
                  // Threshold is tested before the wrap so a wrap-bit error counts in the old window.
                  if (mismatch && win_err == WERR_W'(ERR_THRESH - 1)) begin
                     state    <= FILL;
                     locked   <= 1'b0;
                     win_err  <= '0;
                     win_cnt  <= '0;
                     fill_cnt <= '0;
                     good_cnt <= '0;
                  end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt + 1'b1;
                     if (mismatch) begin
                        win_err <= win_err + 1'b1;
                     end
                  end
               end
               default: state <= FILL;
            endcase
         end
         if (clear_cnt) begin
            err_count <= '0;
         end
      end
   end

endmodule
